// File: rtl/complex_type.sv
// Shared complex sample type and FFT frame constants for the FFT streaming datapath.
package complex_type;

    localparam int COMPLEX_W = 32;
    localparam int N_FFT     = 8;
    localparam int FRAC_BITS = 16;

    // Signed Q16.16 real/imaginary pair.
    typedef struct packed {
        logic signed [COMPLEX_W-1:0] r;
        logic signed [COMPLEX_W-1:0] i;
    } Complex;

    typedef enum logic [1:0] {
        LOAD,
        FIRE,
        WAIT
    } in_state_t;

endpackage

// File: rtl/frame_drain.sv
// Holds one captured FFT result and replays it bin by bin as a valid/ready stream.
module frame_drain
    import complex_type::*;
#(
    parameter int N = N_FFT
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   capture,
    input  Complex cap_data [0:N-1],
    input  logic   m_ready,
    output logic   out_busy,
    output logic   m_valid,
    output Complex m_data,
    output logic   m_last
);

    localparam int IW = $clog2(N);

    Complex          obuf [0:N-1];
    logic [IW-1:0]   rd_idx;
    logic            last_bin;

    assign last_bin = (rd_idx == IW'(N - 1));

    // NOTE: the result buffer is reset so m_data reads zero out of reset;
    // drop the clear only if downstream never looks at m_data while m_valid is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_busy <= 1'b0;
            rd_idx   <= '0;
            for (int k = 0; k < N; k++) obuf[k] <= '0;
        end else if (capture) begin
            obuf     <= cap_data;
            out_busy <= 1'b1;
            rd_idx   <= '0;
        end else if (out_busy && m_ready) begin
            if (last_bin) begin
                out_busy <= 1'b0;
                rd_idx   <= '0;
            end else begin
                rd_idx <= rd_idx + 1'b1;
            end
        end
    end

    assign m_valid = out_busy;
    assign m_data  = obuf[rd_idx];
    assign m_last  = out_busy && last_bin;

endmodule

// File: rtl/fft_frame_adapter.sv
// Streaming front/back end for the parallel FFT core: assembles input frames,
// fires the FFT start pulse, captures the result and drains it downstream.
module fft_frame_adapter
    import complex_type::*;
#(
    parameter int N = N_FFT,
    parameter int W = COMPLEX_W
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   s_valid,
    output logic   s_ready,
    input  Complex s_data,
    output logic   fft_valid,
    output Complex fft_data_in [0:N-1],
    input  logic   fft_ready,
    input  Complex fft_data_out [0:N-1],
    output logic   m_valid,
    input  logic   m_ready,
    output Complex m_data,
    output logic   m_last
);

    localparam int IW = $clog2(N);

    in_state_t     state_q, state_d;
    logic [IW-1:0] wr_idx;
    Complex        ibuf [0:N-1];
    logic          out_busy;
    logic          accept;
    logic          last_in;
    logic          capture;

    assign accept  = s_valid && s_ready;
    assign last_in = (wr_idx == IW'(N - 1));
    // Registered out_busy keeps m_ready off the capture path.
    assign capture = (state_q == WAIT) && fft_ready && !out_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= LOAD;
        else        state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; a missing default here would infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LOAD:    if (accept && last_in) state_d = FIRE;
            FIRE:    state_d = WAIT;
            WAIT:    if (capture) state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    always_comb begin
        s_ready   = 1'b0;
        fft_valid = 1'b0;
        unique case (state_q)
            LOAD:    s_ready = 1'b1;
            FIRE:    fft_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx <= '0;
            for (int k = 0; k < N; k++) ibuf[k] <= '{r: W'(0), i: W'(0)};
        end else if (accept) begin
            ibuf[wr_idx] <= s_data;
            wr_idx       <= last_in ? '0 : wr_idx + 1'b1;
        end
    end

    assign fft_data_in = ibuf;

    frame_drain #(.N(N)) u_drain (
        .clk      (clk),
        .rst_n    (rst_n),
        .capture  (capture),
        .cap_data (fft_data_out),
        .m_ready  (m_ready),
        .out_busy (out_busy),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_last   (m_last)
    );

endmodule

// File: tb/tb_fft_frame_adapter.sv
// Self-checking bench for fft_frame_adapter with a behavioural FFT core and
// a queue-based reference of the frame/stream behaviour.
module tb_fft_frame_adapter;
    import complex_type::*;

    localparam int N = N_FFT;

    logic   clk = 1'b0;
    logic   rst_n = 1'b1;
    logic   s_valid = 1'b0;
    logic   s_ready;
    Complex s_data = '0;
    logic   fft_valid;
    Complex fft_data_in [0:N-1];
    logic   fft_ready = 1'b0;
    Complex fft_data_out [0:N-1];
    logic   m_valid;
    logic   m_ready = 1'b1;
    Complex m_data;
    logic   m_last;

    always #5 clk = ~clk;

    fft_frame_adapter #(.N(N), .W(COMPLEX_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .fft_valid    (fft_valid),
        .fft_data_in  (fft_data_in),
        .fft_ready    (fft_ready),
        .fft_data_out (fft_data_out),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last)
    );

    int n_compared = 0;
    int n_mismatched = 0;

    // Reference state: frame fill count, loaded-frame phase, bins left to drain.
    Complex ref_ibuf [0:N-1];
    Complex exp_q [$];
    Complex rx_log [$];
    int     acc_cnt = 0;
    int     remaining = 0;
    bit     pending = 0, pulse_due = 0, waiting = 0;
    int     cycle = 0, beats_seen = 0, pulse_count = 0;
    int     last_accept_cycle = 0, last_pulse_cycle = 0;

    Complex tx_frame [0:N-1];
    int     fft_lat = 3;
    int     mr_mode = 0;

    always @(negedge clk) begin : monitor
        logic [3:0] exp_flags;
        bit hs, cap, acc, din_ok;
        cycle++;
        if (!rst_n) begin
            acc_cnt = 0; remaining = 0; pending = 0; pulse_due = 0; waiting = 0;
            exp_q.delete();
            for (int k = 0; k < N; k++) ref_ibuf[k] = '0;
        end else begin
            exp_flags = {~pending, pulse_due, (remaining != 0), (remaining == 1)};
            n_compared++;
            if ({s_ready, fft_valid, m_valid, m_last} !== exp_flags) begin
                n_mismatched++;
                $display("FAIL flags @%0d: got %b expected %b (s_ready,fft_valid,m_valid,m_last)",
                         cycle, {s_ready, fft_valid, m_valid, m_last}, exp_flags);
            end
            if (remaining != 0) begin
                n_compared++;
                if (m_data !== exp_q[0]) begin
                    n_mismatched++;
                    $display("FAIL m_data @%0d: got %h expected %h", cycle, m_data, exp_q[0]);
                end
            end
            din_ok = 1;
            for (int k = 0; k < N; k++) if (fft_data_in[k] !== ref_ibuf[k]) din_ok = 0;
            n_compared++;
            if (!din_ok) begin
                n_mismatched++;
                $display("FAIL fft_data_in @%0d: got [0]=%h [N-1]=%h expected [0]=%h [N-1]=%h",
                         cycle, fft_data_in[0], fft_data_in[N-1], ref_ibuf[0], ref_ibuf[N-1]);
            end
            if (fft_valid) begin
                pulse_count++;
                last_pulse_cycle = cycle;
            end
            hs  = (remaining != 0) && m_ready;
            cap = waiting && fft_ready && (remaining == 0);
            acc = s_valid && !pending;
            if (hs) begin
                rx_log.push_back(m_data);
                beats_seen++;
                void'(exp_q.pop_front());
                remaining--;
            end
            if (cap) begin
                for (int k = 0; k < N; k++) exp_q.push_back(fft_data_out[k]);
                remaining = N;
                pending = 0;
                waiting = 0;
            end
            if (pulse_due) begin
                pulse_due = 0;
                waiting = 1;
            end
            if (acc) begin
                ref_ibuf[acc_cnt] = s_data;
                acc_cnt++;
                last_accept_cycle = cycle;
                if (acc_cnt == N) begin
                    acc_cnt = 0;
                    pending = 1;
                    pulse_due = 1;
                end
            end
        end
    end

    // Behavioural FFT core: plain DFT, ready raised fft_lat cycles after the pulse.
    initial begin : fft_model
        Complex frame [0:N-1];
        int     cd;
        bit     fired;
        real    sr, si, xr, xi, ang;
        cd = 0;
        fired = 0;
        for (int k = 0; k < N; k++) fft_data_out[k] = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cd = 0; fired = 0; fft_ready = 1'b0;
            end else if (fft_valid) begin
                frame = fft_data_in;
                cd = fft_lat;
                fired = 1;
            end
            @(posedge clk); #1;
            if (rst_n) begin
                if (fired) begin
                    fft_ready = 1'b0;
                    fired = 0;
                end
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        for (int k = 0; k < N; k++) begin
                            sr = 0.0; si = 0.0;
                            for (int n = 0; n < N; n++) begin
                                xr = $itor($signed(frame[n].r));
                                xi = $itor($signed(frame[n].i));
                                ang = -2.0 * 3.14159265358979 * k * n / N;
                                sr += xr * $cos(ang) - xi * $sin(ang);
                                si += xr * $sin(ang) + xi * $cos(ang);
                            end
                            fft_data_out[k].r = $rtoi(sr >= 0.0 ? sr + 0.5 : sr - 0.5);
                            fft_data_out[k].i = $rtoi(si >= 0.0 ? si + 0.5 : si - 0.5);
                        end
                        fft_ready = 1'b1;
                    end
                end
            end
        end
    end

    // Downstream ready: 0 always, 1 pattern 1,0,0, 2 random.
    initial begin : m_ready_drv
        int phase = 0;
        forever begin
            @(posedge clk); #1;
            case (mr_mode)
                1:       m_ready = (phase % 3 == 0);
                2:       m_ready = 1'($urandom_range(0, 1));
                default: m_ready = 1'b1;
            endcase
            phase++;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // Entered and left at posedge+1.
    task automatic send_frame(input bit gaps);
        for (int k = 0; k < N; k++) begin
            int budget = 0;
            bit done = 0;
            while (!done) begin
                if (gaps && !s_ready) begin
                    s_valid = 1'b1;
                    s_data  = {$urandom, $urandom};
                end else if (gaps && $urandom_range(0, 2) == 0) begin
                    s_valid = 1'b0;
                    s_data  = {$urandom, $urandom};
                end else begin
                    s_valid = 1'b1;
                    s_data  = tx_frame[k];
                end
                @(negedge clk);
                done = s_valid && s_ready && (s_data == tx_frame[k]);
                @(posedge clk); #1;
                budget++;
                if (!done && budget > 400) begin
                    n_compared++; n_mismatched++;
                    $display("FAIL send_timeout: sample %0d not accepted, got no accept expected accept", k);
                    done = 1;
                end
            end
        end
        s_valid = 1'b0;
        s_data  = {$urandom, $urandom};
    endtask

    task automatic wait_idle();
        int budget = 0;
        do begin
            @(negedge clk); #2;
            budget++;
        end while ((pending || remaining != 0 || acc_cnt != 0) && budget < 2000);
        if (budget >= 2000) begin
            n_compared++; n_mismatched++;
            $display("FAIL idle_timeout: got pending=%0d remaining=%0d expected 0/0", pending, remaining);
        end
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        bit zero = 1;
        for (int k = 0; k < N; k++) if (fft_data_in[k] !== '0) zero = 0;
        n_compared++;
        if ({s_ready, fft_valid, m_valid, m_last} !== 4'b1000) begin
            n_mismatched++;
            $display("FAIL %s_flags: got %b expected 1000", tag, {s_ready, fft_valid, m_valid, m_last});
        end
        n_compared++;
        if (m_data !== '0) begin
            n_mismatched++;
            $display("FAIL %s_m_data: got %h expected 0", tag, m_data);
        end
        n_compared++;
        if (!zero) begin
            n_mismatched++;
            $display("FAIL %s_fft_data_in: got [0]=%h expected all zero", tag, fft_data_in[0]);
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2 check_reset_outputs("reset");
        @(negedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_ramp();
        int pc0 = pulse_count;
        int rx0 = rx_log.size();
        mr_mode = 0; fft_lat = 3;
        for (int k = 0; k < N; k++) begin
            tx_frame[k].r = 32'(k << 12);
            tx_frame[k].i = '0;
        end
        send_frame(0);
        wait_idle();
        n_compared++;
        if (pulse_count - pc0 != 1) begin
            n_mismatched++;
            $display("FAIL ramp_pulses: got %0d expected 1", pulse_count - pc0);
        end
        n_compared++;
        if (last_pulse_cycle - last_accept_cycle != 1) begin
            n_mismatched++;
            $display("FAIL ramp_pulse_timing: got %0d cycles after accept expected 1",
                     last_pulse_cycle - last_accept_cycle);
        end
        n_compared++;
        if (rx_log.size() - rx0 != N) begin
            n_mismatched++;
            $display("FAIL ramp_beats: got %0d expected %0d", rx_log.size() - rx0, N);
        end else begin
            n_compared++;
            if (rx_log[rx0] !== {32'h0001C000, 32'h0}) begin
                n_mismatched++;
                $display("FAIL ramp_bin0: got %h expected 0001c00000000000", rx_log[rx0]);
            end
        end
    endtask

    task automatic test_impulse(input string tag);
        int rx0 = rx_log.size();
        mr_mode = 0; fft_lat = 2;
        for (int k = 0; k < N; k++) tx_frame[k] = '0;
        tx_frame[0].r = 32'h0001_0000;
        send_frame(0);
        wait_idle();
        n_compared++;
        if (rx_log.size() - rx0 != N) begin
            n_mismatched++;
            $display("FAIL %s_beats: got %0d expected %0d", tag, rx_log.size() - rx0, N);
        end else begin
            for (int k = 0; k < N; k++) begin
                n_compared++;
                if (rx_log[rx0 + k] !== {32'h0001_0000, 32'h0}) begin
                    n_mismatched++;
                    $display("FAIL %s_bin%0d: got %h expected 0001000000000000", tag, k, rx_log[rx0 + k]);
                end
            end
        end
    endtask

    task automatic random_frame();
        for (int k = 0; k < N; k++) begin
            tx_frame[k].r = 32'($urandom_range(0, 2097151)) - 32'd1048576;
            tx_frame[k].i = 32'($urandom_range(0, 2097151)) - 32'd1048576;
        end
    endtask

    task automatic test_backpressure();
        int rx0 = rx_log.size();
        mr_mode = 1; fft_lat = 4;
        random_frame();
        send_frame(0);
        wait_idle();
        n_compared++;
        if (rx_log.size() - rx0 != N || exp_q.size() != 0) begin
            n_mismatched++;
            $display("FAIL backpressure_beats: got %0d (left %0d) expected %0d (left 0)",
                     rx_log.size() - rx0, exp_q.size(), N);
        end
    endtask

    task automatic test_overlap();
        longint sr = 0, si = 0;
        int budget = 0;
        Complex bin0;
        mr_mode = 1; fft_lat = 3;
        random_frame();
        send_frame(0);
        fft_lat = 1;
        random_frame();
        for (int k = 0; k < N; k++) begin
            sr += longint'($signed(tx_frame[k].r));
            si += longint'($signed(tx_frame[k].i));
        end
        bin0.r = 32'(sr);
        bin0.i = 32'(si);
        send_frame(0);
        n_compared++;
        if (m_valid !== 1'b1) begin
            n_mismatched++;
            $display("FAIL overlap_drain_active: got m_valid=%b expected 1", m_valid);
        end
        do begin
            @(negedge clk);
            budget++;
        end while (!(m_valid && m_ready && m_last) && budget < 300);
        @(negedge clk);
        n_compared++;
        if (m_valid !== 1'b0) begin
            n_mismatched++;
            $display("FAIL overlap_gap: got m_valid=%b expected 0", m_valid);
        end
        @(negedge clk);
        n_compared++;
        if (m_valid !== 1'b1 || m_data !== bin0) begin
            n_mismatched++;
            $display("FAIL overlap_frame2_bin0: got v=%b %h expected v=1 %h", m_valid, m_data, bin0);
        end
        @(posedge clk); #1;
        wait_idle();
    endtask

    task automatic test_input_gaps();
        int rx0 = rx_log.size();
        mr_mode = 2;
        for (int f = 0; f < 3; f++) begin
            fft_lat = $urandom_range(1, 5);
            random_frame();
            send_frame(1);
        end
        wait_idle();
        n_compared++;
        if (rx_log.size() - rx0 != 3 * N) begin
            n_mismatched++;
            $display("FAIL gaps_beats: got %0d expected %0d", rx_log.size() - rx0, 3 * N);
        end
    endtask

    task automatic test_reset_mid_drain();
        int b0;
        int budget = 0;
        mr_mode = 1; fft_lat = 2;
        random_frame();
        send_frame(0);
        b0 = beats_seen;
        do begin
            @(negedge clk); #2;
            budget++;
        end while (beats_seen < b0 + 3 && budget < 200);
        rst_n = 1'b0;
        #1 check_reset_outputs("mid_drain_reset");
        @(negedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        test_impulse("after_reset");
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_impulse("impulse");
        test_backpressure();
        test_overlap();
        test_input_gaps();
        test_reset_mid_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
